// File: rtl/imem_loader_if.sv
// Stream-in and memory-write bus of the instruction memory loader.
// Stream handshake: a byte moves from source to loader on a rising clk edge
// where in_valid && in_ready are both high; the source holds in_byte stable
// while in_valid is high and not yet accepted, and in_ready never depends
// combinationally on in_valid.
// Write port: one word is written on every rising edge where wr_en is high.
interface imem_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Loader side: consumes the stream, drives the memory write port.
    modport master (
        input  in_byte, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );

    // Environment side: byte source plus instruction memory.
    modport slave (
        output in_byte, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream (MSB first) into 32-bit instructions and
// writes DEPTH words to instruction memory starting at address 0, holding
// the CPU stalled while the load runs.
// Optional feature: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte after the last word; a mismatch raises err together with done.
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    imem_loader_if.master bus,
    output logic         busy,
    output logic         done,
    output logic         cpu_stall,
    output logic         err,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_CHK   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] word;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic              done_q;
    logic              accept;
    logic              last_word;
    logic              start_ok;

    assign accept    = bus.in_valid && bus.in_ready;
    assign last_word = (wr_addr == ADDR_W'(DEPTH - 1));
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));

    // Outputs decoded from state; all are 0 in IDLE, which reset selects.
    assign bus.in_ready = (state == S_RECV) || (state == S_CHK);
    assign bus.wr_en    = (state == S_WRITE);
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_data  = word;
    assign busy         = (state == S_RECV) || (state == S_WRITE) || (state == S_CHK);
    assign cpu_stall    = busy;
    assign done         = done_q;
    assign dbg_state    = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: RECV collects 4 bytes, WRITE stores one word.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = S_RECV;
            end
            S_RECV: begin
                if (accept && (byte_cnt == 2'd3)) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = S_CHK;
`else
                    state_nxt = S_DONE;
`endif
                end else begin
                    state_nxt = S_RECV;
                end
            end
            S_CHK: begin
                if (accept) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: byte packing, write address, done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            byte_cnt <= '0;
            wr_addr  <= '0;
            done_q   <= 1'b0;
        end else begin
            if (start_ok) begin
                wr_addr  <= '0;
                byte_cnt <= '0;
                done_q   <= 1'b0;
            end
            if ((state == S_RECV) && accept) begin
                word     <= {word[DATA_W-9:0], bus.in_byte};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == S_WRITE) begin
                byte_cnt <= '0;
                // Address saturates at the last word instead of wrapping.
                if (!last_word) wr_addr <= wr_addr + 1'b1;
`ifndef IMEM_LOADER_CHECKSUM_EN
                if (last_word) done_q <= 1'b1;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if ((state == S_CHK) && accept) done_q <= 1'b1;
`endif
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xor_acc;
    logic       err_q;

    // Running XOR of data bytes; the trailing byte is checked against it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_acc <= '0;
            err_q   <= 1'b0;
        end else begin
            if (start_ok) begin
                xor_acc <= '0;
                err_q   <= 1'b0;
            end
            if ((state == S_RECV) && accept) xor_acc <= xor_acc ^ bus.in_byte;
            if ((state == S_CHK) && accept)  err_q   <= (bus.in_byte != xor_acc);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: drives byte streams, models the packed words
// in a scoreboard queue and compares every memory write against it.
module tb_imem_loader;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
    localparam int DATA_W = 32;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int LOAD_CYCLES = 161;
`else
    localparam int LOAD_CYCLES = 160;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, cpu_stall, err;
    logic [2:0] dbg_state;

    imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .cpu_stall (cpu_stall),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- memory model + scoreboard ----------------
    logic [DATA_W-1:0]        mem [DEPTH];
    bit                       written [DEPTH];
    int                       wr_pulses = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0]        m_word;
    int                       m_cnt;
    int                       m_addr;

    task automatic model_reset();
        m_word = '0;
        m_cnt  = 0;
        m_addr = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [7:0] b);
        logic [ADDR_W-1:0] a;
        m_word = {m_word[DATA_W-9:0], b};
        m_cnt++;
        if (m_cnt == 4) begin
            a = m_addr[ADDR_W-1:0];
            exp_q.push_back({a, m_word});
            m_cnt = 0;
            m_addr++;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'hDEAD_BEEF;
            written[i] = 1'b0;
        end
        wr_pulses = 0;
    endtask

    // Every write is captured into the memory model and checked in order.
    always @(negedge clk) begin
        logic [ADDR_W+DATA_W-1:0] e;
        if (rst_n && bus.wr_en) begin
            mem[bus.wr_addr]     = bus.wr_data;
            written[bus.wr_addr] = 1'b1;
            wr_pulses++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            check("wr_addr_data", 64'({bus.wr_addr, bus.wr_data}), 64'(e));
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 64'(bus.in_ready), 64'd1);
        end else begin
            @(posedge clk);
            model_accept(b);
            @(negedge clk);
        end
    endtask

    task automatic send_load(input int max_gap, input int nbytes);
        for (int i = 0; i < nbytes; i++) send_byte(8'(i), $urandom_range(0, max_gap));
        bus.in_valid = 1'b0;
    endtask

    task automatic send_trailer(input logic [7:0] b);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(b, 0);
        bus.in_valid = 1'b0;
`else
        b = b;
`endif
    endtask

    function automatic logic exp_err(input logic [7:0] trailer);
`ifdef IMEM_LOADER_CHECKSUM_EN
        return trailer != 8'h00;
`else
        return trailer != trailer;
`endif
    endfunction

    task automatic pulse_start();
        bus.in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_reset();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_wr_en"},    64'(bus.wr_en),    64'd0);
        check({tag, "_wr_addr"},  64'(bus.wr_addr),  64'd0);
        check({tag, "_wr_data"},  64'(bus.wr_data),  64'd0);
        check({tag, "_busy"},     64'(busy),         64'd0);
        check({tag, "_done"},     64'(done),         64'd0);
        check({tag, "_stall"},    64'(cpu_stall),    64'd0);
        check({tag, "_err"},      64'(err),          64'd0);
        check({tag, "_state"},    64'(dbg_state),    64'd0);
    endtask

    task automatic check_image(input string tag);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            w = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
            check(tag, 64'(mem[i]), 64'(w));
        end
    endtask

    task automatic check_done_outputs(input string tag, input logic [7:0] trailer);
        check({tag, "_pulses"}, 64'(wr_pulses),    64'd32);
        check({tag, "_busy"},   64'(busy),         64'd0);
        check({tag, "_stall"},  64'(cpu_stall),    64'd0);
        check({tag, "_ready"},  64'(bus.in_ready), 64'd0);
        check({tag, "_addr"},   64'(bus.wr_addr),  64'(DEPTH - 1));
        check({tag, "_err"},    64'(err),          64'(exp_err(trailer)));
        check({tag, "_q"},      64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    int t0;
    int p0;

    initial begin
        bus.in_byte  = 8'h00;
        bus.in_valid = 1'b0;
        clear_mem();
        model_reset();

        // Reset held for 3 cycles.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_no_write", 64'(wr_pulses), 64'd0);

        // Back-to-back load with in_valid held high.
        clear_mem();
        pulse_start();
        t0 = cyc;
        check("start_busy",  64'(busy),      64'd1);
        check("start_stall", 64'(cpu_stall), 64'd1);
        send_load(0, 128);
        send_trailer(8'h00);
        wait_done("load0_done");
        check("load0_cycles", 64'(cyc - t0), 64'(LOAD_CYCLES));
        check("load0_addr0",  64'(mem[0]),  64'h0001_0203);
        check("load0_addr31", 64'(mem[31]), 64'h7C7D_7E7F);
        check_done_outputs("load0", 8'h00);

        // Bytes offered while DONE are not consumed.
        p0 = wr_pulses;
        bus.in_byte  = 8'hA5;
        bus.in_valid = 1'b1;
        repeat (6) @(negedge clk);
        bus.in_valid = 1'b0;
        check("done_ignores_bytes", 64'(wr_pulses), 64'(p0));
        check("done_held", 64'(done), 64'd1);

        // Random valid gaps; valid also held across WRITE cycles.
        clear_mem();
        pulse_start();
        send_load(3, 128);
        send_trailer(8'h00);
        wait_done("load1_done");
        check_image("load1_image");
        check_done_outputs("load1", 8'h00);

        // start pulsed mid-load must be ignored.
        clear_mem();
        pulse_start();
        for (int i = 0; i < 128; i++) begin
            if (i == 20) start = 1'b1;
            send_byte(8'(i), $urandom_range(0, 1));
            start = 1'b0;
        end
        bus.in_valid = 1'b0;
        send_trailer(8'h00);
        wait_done("load2_done");
        check_image("load2_image");
        check_done_outputs("load2", 8'h00);

        // Restart after done, then reset after 10 bytes.
        clear_mem();
        pulse_start();
        check("restart_done_low", 64'(done), 64'd0);
        check("restart_busy",     64'(busy), 64'd1);
        send_load(2, 10);
        check("partial_pulses", 64'(wr_pulses), 64'd2);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("midrst_pulses", 64'(wr_pulses), 64'd2);
        check("midrst_w0", 64'(written[0]), 64'd1);
        check("midrst_w1", 64'(written[1]), 64'd1);
        check("midrst_w2", 64'(written[2]), 64'd0);
        check("midrst_addr0", 64'(mem[0]), 64'h0001_0203);
        check("midrst_addr1", 64'(mem[1]), 64'h0405_0607);

        // Fresh load after reset, trailer 0x55.
        clear_mem();
        pulse_start();
        send_load(2, 128);
        send_trailer(8'h55);
        wait_done("load3_done");
        check_image("load3_image");
        check_done_outputs("load3", 8'h55);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
